// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard controller for a 5-stage in-order pipeline (IF/ID/EX/MEM/WB).
// It produces the pipeline register load enables and bubble (flush) controls
// from three hazard sources, in priority order:
//   1. memory freeze   : data memory in MEM has not completed -> whole pipe holds
//   2. taken branch    : EX resolved a taken branch/jump -> squash IF/ID, ID/EX
//   3. load-use        : ID reads a register that the load in EX will write
//                        -> hold PC and IF/ID for one cycle, bubble into ID/EX
//
// A two-state FSM (RUN / MEM_WAIT) tracks an outstanding memory access.
// Enables and flushes are purely combinational from the state and the inputs.
// An 8-bit wait counter measures the memory wait; mem_timeout is a sticky flag
// raised when the wait reaches MEM_TIMEOUT cycles (the controller keeps
// waiting regardless).
//
// Handshake note: mem_req/mem_ready form a level-based completion handshake.
// The MEM access is in flight while mem_req=1 (RUN) or while in MEM_WAIT; the
// access completes in the cycle mem_ready=1, and that cycle runs unfrozen.
//
// Build option:
//   HAZARD_PERF_CNT_EN  when defined, lu_stall_cnt / mem_stall_cnt / flush_cnt
//                       are saturating 16-bit counters of load-use stall,
//                       freeze and branch-flush cycles. When undefined they are
//                       tied to 0 and no counter logic exists.
//
// Parameters:
//   MEM_TIMEOUT    wait-cycle count (1..255) at which mem_timeout sets
//
// Ports:
//   clock          sole clock, rising edge
//   reset          synchronous active-low reset
//   id_rs1/id_rs2  source registers of the ID instruction
//   id_uses_rs1/2  ID instruction actually reads that source
//   ex_rd          destination register of the EX instruction
//   ex_memtoreg    EX instruction is a load
//   ex_reg_en      EX instruction writes the register file
//   branch_taken   EX resolved a taken branch or jump
//   mem_req        MEM instruction accesses data memory
//   mem_ready      data memory completes this cycle
//   pc_en .. mem_wb_en          pipeline register load enables
//   if_id_flush, id_ex_flush    load a bubble into IF/ID or ID/EX
//   mem_timeout    sticky memory-wait timeout flag
//   lu_stall_cnt, mem_stall_cnt, flush_cnt   performance counters
//   state_dbg      current FSM state (0 = RUN, 1 = MEM_WAIT)
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_memtoreg,
    input  logic        ex_reg_en,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_timeout,
    output logic [15:0] lu_stall_cnt,
    output logic [15:0] mem_stall_cnt,
    output logic [15:0] flush_cnt,
    output logic        state_dbg
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t     state;
    state_t     state_next;
    logic       freeze;
    logic       load_use;
    logic [7:0] wait_cnt;

    assign state_dbg = (state == MEM_WAIT);

    // Next state and hazard outputs.
    always_comb begin
        freeze = ((state == RUN) && mem_req && !mem_ready) ||
                 ((state == MEM_WAIT) && !mem_ready);

        // A load only hurts when it really writes a non-zero register that
        // the ID instruction actually reads.
        load_use = ex_memtoreg && ex_reg_en && (ex_rd != 5'd0) &&
                   ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                    (id_uses_rs2 && (id_rs2 == ex_rd)));

        state_next  = freeze ? MEM_WAIT : RUN;

        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;

        if (freeze) begin
            // Everything holds. A taken branch stays in the frozen EX stage
            // and is acted on in the first unfrozen cycle.
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (branch_taken) begin
            // The two younger instructions are wrong-path; a coincident
            // load-use is on the wrong path too and is ignored.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            // The bubble in ID/EX removes the load from EX next cycle, so the
            // stall naturally lasts one cycle.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Wait counter holds 0 in RUN and counts MEM_WAIT cycles, so in the Nth
    // MEM_WAIT cycle it reads N (saturating).
    always_ff @(posedge clock) begin
        if (!reset || (state_next == RUN)) begin
            wait_cnt <= 8'd0;
        end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            mem_timeout <= 1'b0;
        end else if ((state == MEM_WAIT) && (wait_cnt == TIMEOUT_CNT)) begin
            mem_timeout <= 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic lu_evt;
    logic flush_evt;

    assign lu_evt    = !freeze && !branch_taken && load_use;
    assign flush_evt = !freeze && branch_taken;

    always_ff @(posedge clock) begin
        if (!reset) begin
            lu_stall_cnt  <= 16'd0;
            mem_stall_cnt <= 16'd0;
            flush_cnt     <= 16'd0;
        end else begin
            if (lu_evt && (lu_stall_cnt != 16'hFFFF)) begin
                lu_stall_cnt <= lu_stall_cnt + 16'd1;
            end
            if (freeze && (mem_stall_cnt != 16'hFFFF)) begin
                mem_stall_cnt <= mem_stall_cnt + 16'd1;
            end
            if (flush_evt && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`else
    assign lu_stall_cnt  = 16'd0;
    assign mem_stall_cnt = 16'd0;
    assign flush_cnt     = 16'd0;
`endif

endmodule
